// File: rtl/switch_event_arbiter_if.sv
// rtl/switch_event_arbiter_if.sv - switch inputs, arm control and event stream bundle for switch_event_arbiter
//
// Signals:
//   sw_level      debounced switch levels (synchronous to clk)
//   arm           1 = capture edges, 0 = ignore edges and flush pending
//   event_ready   consumer accepts the offered event
//   event_valid   an event is offered
//   event_id      index of the switch that caused the event
//   event_release 1 = release event (fall-edge build only, else 0)
//   pending       per-switch pending press mask
//   drop_count    saturating count of dropped events
// Modports:
//   master  arbiter side (drives the event stream and status)
//   slave   switch/consumer side (drives levels, arm and ready)
interface switch_event_arbiter_if #(
    parameter int NUM_SWITCHES = 22,
    parameter int ID_W         = 5,
    parameter int DROP_W       = 8
) ();
    logic [NUM_SWITCHES-1:0] sw_level;
    logic                    arm;
    logic                    event_ready;
    logic                    event_valid;
    logic [ID_W-1:0]         event_id;
    logic                    event_release;
    logic [NUM_SWITCHES-1:0] pending;
    logic [DROP_W-1:0]       drop_count;

    modport master (
        input  sw_level, arm, event_ready,
        output event_valid, event_id, event_release, pending, drop_count
    );

    modport slave (
        output sw_level, arm, event_ready,
        input  event_valid, event_id, event_release, pending, drop_count
    );
endinterface

// File: rtl/switch_event_arbiter.sv
// rtl/switch_event_arbiter.sv - round-robin serialiser of switch press events onto a valid/ready stream
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    switch_event_arbiter_if.master (sw_level, arm, event_ready in;
//          event_valid, event_id, event_release, pending, drop_count out)
// Optional feature macro: SWITCH_EVENT_FALL_EDGE_EN
//   defined   -> falling edges are queued as release events (sources
//                NUM_SWITCHES..2*NUM_SWITCHES-1) and event_release marks them
//   undefined -> falls are ignored and event_release is tied 0
module switch_event_arbiter #(
    parameter int NUM_SWITCHES = 22,
    parameter int ID_W         = 5,
    parameter int DROP_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    switch_event_arbiter_if.master bus
);

`ifdef SWITCH_EVENT_FALL_EDGE_EN
    localparam int NSRC = 2 * NUM_SWITCHES;
`else
    localparam int NSRC = NUM_SWITCHES;
`endif
    localparam int RR_W = $clog2(NSRC);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                  state_q;
    logic [NUM_SWITCHES-1:0] sw_prev_q;
    logic [NSRC-1:0]         req_q;
    logic [NSRC-1:0]         req_d;
    logic [NSRC-1:0]         src_edge;
    logic [NSRC-1:0]         grant_mask;
    logic [RR_W-1:0]         rr_ptr_q;
    logic [RR_W-1:0]         grant_idx;
    logic                    grant_found;
    logic                    grant_en;
    logic [ID_W-1:0]         grant_sw;
    logic                    event_valid_q;
    logic [ID_W-1:0]         event_id_q;
    logic                    drop_any;
    logic [DROP_W-1:0]       drop_q;
    logic [DROP_W-1:0]       drop_d;

`ifdef SWITCH_EVENT_FALL_EDGE_EN
    logic grant_rel;
    logic event_release_q;

    // Source vector: presses in the low half, releases in the high half.
    assign src_edge  = {~bus.sw_level & sw_prev_q, bus.sw_level & ~sw_prev_q};
    assign grant_rel = (grant_idx >= RR_W'(NUM_SWITCHES));
    assign grant_sw  = grant_rel ? ID_W'(grant_idx - RR_W'(NUM_SWITCHES)) : ID_W'(grant_idx);
`else
    assign src_edge  = bus.sw_level & ~sw_prev_q;
    assign grant_sw  = ID_W'(grant_idx);
`endif

    // Round-robin search: first requesting source strictly after rr_ptr_q,
    // wrapping modulo NSRC (NSRC need not be a power of two).
    always_comb begin : search
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int k = 0; k < NSRC; k++) begin
            j = int'(rr_ptr_q) + 1 + k;
            if (j >= NSRC) begin
                j = j - NSRC;
            end
            if (!grant_found && req_q[j[RR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = j[RR_W-1:0];
            end
        end
    end

    assign grant_en   = (state_q == IDLE) && grant_found;
    assign grant_mask = grant_en ? (NSRC'(1) << grant_idx) : '0;

    // A new edge on a source being granted this cycle re-arms it (set wins)
    // and is not a drop; several drops in one cycle count once.
    always_comb begin
        req_d    = req_q & ~grant_mask;
        drop_any = 1'b0;
        if (bus.arm) begin
            drop_any = |(src_edge & req_q & ~grant_mask);
            req_d    = req_d | src_edge;
        end else begin
            req_d = '0;
        end
        drop_d = drop_q;
        if (drop_any && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // sw_prev loads the live levels at reset so switches already high
    // do not produce a press when reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_prev_q <= bus.sw_level;
            req_q     <= '0;
            drop_q    <= '0;
        end else begin
            sw_prev_q <= bus.sw_level;
            req_q     <= req_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            event_valid_q <= 1'b0;
            event_id_q    <= '0;
            rr_ptr_q      <= RR_W'(NSRC - 1);
`ifdef SWITCH_EVENT_FALL_EDGE_EN
            event_release_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        state_q       <= OFFER;
                        event_valid_q <= 1'b1;
                        event_id_q    <= grant_sw;
                        rr_ptr_q      <= grant_idx;
`ifdef SWITCH_EVENT_FALL_EDGE_EN
                        event_release_q <= grant_rel;
`endif
                    end
                end
                OFFER: begin
                    // The offered event is never withdrawn or altered.
                    if (bus.event_ready) begin
                        state_q       <= IDLE;
                        event_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    event_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.event_valid = event_valid_q;
    assign bus.event_id    = event_id_q;
    assign bus.pending     = req_q[NUM_SWITCHES-1:0];
    assign bus.drop_count  = drop_q;
`ifdef SWITCH_EVENT_FALL_EDGE_EN
    assign bus.event_release = event_release_q;
`else
    assign bus.event_release = 1'b0;
`endif

endmodule

// File: doc/switch_event_arbiter.md
Name: switch_event_arbiter

Overview:
- Sits between the per-switch debounce bank and the game FSM.
- Takes NUM_SWITCHES debounced level inputs and converts rising edges into one-shot press events.
- Queues one pending event per switch and serialises them round-robin onto a single valid/ready event stream.
- The consumer therefore sees exactly one switch ID per accepted transfer, and no simultaneous press is lost unless that switch re-presses while still pending.

Parameters:
- NUM_SWITCHES, 22: number of debounced inputs (18 SW + 4 KEY); legal range 2..32.
- ID_W, 5: event ID width; must satisfy 2^ID_W >= NUM_SWITCHES.
- DROP_W, 8: width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- sw_level  in  NUM_SWITCHES  debounced switch levels, already synchronous to clk
- arm  in  1  1 = capture edges; 0 = ignore edges and flush pending
- event_ready  in  1  consumer accepts the offered event
- event_valid  out  1  an event is offered
- event_id  out  ID_W  index of the switch that caused the event
- event_release  out  1  1 = release event (FALL_EDGE_EN only; otherwise tied 0)
- pending  out  NUM_SWITCHES  per-switch pending-event mask
- drop_count  out  DROP_W  saturating count of dropped events

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - event_valid=0, event_id=0, event_release=0, pending=0, drop_count=0.
  - rr_ptr=NUM_SWITCHES-1, state=IDLE.
  - sw_prev loads sw_level, not 0, so switches already high at reset produce no event.
- Edge detect:
  - rise[i] = sw_level[i] & ~sw_prev[i].
  - sw_prev <= sw_level every cycle, regardless of arm.
- Capture, when arm=1:
  - rise[i] & ~pending[i]: pending[i] <= 1.
  - rise[i] & pending[i]: event dropped; drop_count += 1, saturating at all-ones.
  - Several simultaneous drops in one cycle add 1 only.
  - An edge on bit i in the same cycle bit i is granted (cleared): set wins, pending[i] stays 1, no drop.
- arm=0:
  - pending <= 0 and rise is ignored.
  - An event already in OFFER stays offered until accepted.
- Latency: a rise sampled at edge N sets pending at N+1. event_valid rises at N+2 at the earliest, when in IDLE with no other grant.
- State machine:
  - IDLE: if pending != 0, grant the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_SWITCHES.
    - On grant: event_id <= grant index, pending[grant] <= 0, rr_ptr <= grant, event_valid <= 1, go to OFFER.
    - If pending == 0, stay in IDLE with event_valid=0.
  - OFFER: event_valid=1; event_id and event_release are held stable.
    - event_ready=1: event_valid <= 0, go to IDLE.
    - event_ready=0: hold. Never withdraw or change an offered event.
  - Peak throughput is one event per 2 cycles.
- Fairness: each pending switch is granted within NUM_SWITCHES grants.
- rr_ptr wraps: after granting NUM_SWITCHES-1, the search starts at 0.
- reset during OFFER: event dropped, all state returns to reset values on the next edge.
- event_ready while in IDLE: ignored.

Optional Feature:
- Macro: SWITCH_EVENT_FALL_EDGE_EN.
- Defined:
  - Falling edges (~sw_level[i] & sw_prev[i]) are captured into a second mask, rel_pending, using the same set/drop/arm rules.
  - Arbitration is round-robin over 2*NUM_SWITCHES sources: index i = press i, index NUM_SWITCHES+i = release i.
  - event_id carries i; event_release=1 for release grants.
  - rr_ptr width grows accordingly. pending reports presses only.
- Undefined:
  - Falls are ignored, no rel_pending state is generated, and event_release is constant 0.

Test Plan:
- Reset with sw_level=22'h3FFFFF, release reset, hold 10 cycles -> event_valid stays 0, pending=0, drop_count=0.
- arm=1, event_ready=1, rise on bit 5 at cycle N -> event_valid=1 with event_id=5 at N+2 for exactly 1 cycle; pending[5]=0 afterwards.
- arm=1, event_ready=0, bits 3, 0 and 20 rise together -> first offer id=0, held. Then pulse ready once per offer -> ids 0, 3, 20 in order. Next, a rise on bit 1 with bit 21 already pending -> id 21 before id 1 (rr wrap).
- event_ready=0 and bit 7 offered. Bit 9: rise, fall, rise -> drop_count=1, pending[9]=1. Repeat 300 times -> drop_count saturates at 255.
- pending=bits 2 and 4 with bit 2 in OFFER; drop arm to 0 -> pending=0 the next cycle. Offer of 2 held until ready; no event for 4.
- With SWITCH_EVENT_FALL_EDGE_EN, bit 18: rise then fall 10 cycles later -> events (id=18, release=0) then (id=18, release=1). Without the macro -> only the press event, and event_release is always 0.
